// File: rtl/serializer_with_counter.sv
// Start-bit serial transmitter: one-word hold buffer feeding an LSB-first shifter.
// Optional STOP_BIT_EN adds one idle-level stop cycle before done.
module serializer_with_counter #(
  parameter int   DATA_LENGTH = 16,
  parameter int   WORD_SIZE   = 8,
  parameter logic START_BIT   = 1'b0,
  parameter logic IDLE_BIT    = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] word_in,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic                 data_out,
  output logic                 busy,
  output logic                 RCO,
  output logic                 done,
  output logic                 underrun
);

  localparam int BW = $clog2(WORD_SIZE) + 1;
  localparam int DW = $clog2(DATA_LENGTH) + 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_SIZE - 1);
  localparam logic [DW-1:0] DATA_LAST = DW'(DATA_LENGTH - 1);

`ifdef STOP_BIT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_SHIFT, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_SHIFT
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic                 hold_full_q, hold_full_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]        data_cnt_q, data_cnt_d;
  logic                 underrun_q, underrun_d;
  logic                 done_q, done_d;
  logic                 rco;

  assign rco = (state_q == S_SHIFT) && (bit_cnt_q == BIT_LAST);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    data_cnt_d  = data_cnt_q;
    underrun_d  = underrun_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          underrun_d = 1'b0;
          state_d    = hold_full_q ? S_START : S_WAIT;
        end
      end
      S_WAIT: begin
        if (hold_full_q) state_d = S_START;
      end
      S_START: begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
        bit_cnt_d   = '0;
        data_cnt_d  = '0;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        shift_d    = shift_q >> 1;
        bit_cnt_d  = bit_cnt_q + BW'(1);
        data_cnt_d = data_cnt_q + DW'(1);
        if (data_cnt_q == DATA_LAST) begin
          bit_cnt_d  = '0;
          data_cnt_d = '0;
`ifdef STOP_BIT_EN
          state_d    = S_STOP;
`else
          state_d    = S_IDLE;
          done_d     = 1'b1;
`endif
        end else if (rco) begin
          bit_cnt_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            shift_d    = {WORD_SIZE{IDLE_BIT}};
            underrun_d = 1'b1;
          end
        end
      end
`ifdef STOP_BIT_EN
      S_STOP: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Accept only into an empty hold, so this never races a hold->shift move
    if (word_valid && !hold_full_q) begin
      hold_d      = word_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      data_cnt_q  <= '0;
      underrun_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      data_cnt_q  <= data_cnt_d;
      underrun_q  <= underrun_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    data_out = IDLE_BIT;
    unique case (state_q)
      S_START: data_out = START_BIT;
      S_SHIFT: data_out = shift_q[0];
      default: data_out = IDLE_BIT;
    endcase
  end

  assign word_ready = !hold_full_q;
  assign busy       = (state_q != S_IDLE) || start;
  assign RCO        = rco;
  assign done       = done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_serializer_with_counter.sv
// Bench for serializer_with_counter: frame-position reference model,
// directed scenarios then randomized traffic. Honors STOP_BIT_EN.
module tb_serializer_with_counter;

  localparam int DL = 16;
  localparam int WS = 8;
`ifdef STOP_BIT_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [WS-1:0] word_in;
  logic          word_valid;
  logic          word_ready;
  logic          data_out;
  logic          busy;
  logic          RCO;
  logic          done;
  logic          underrun;

  serializer_with_counter dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .data_out   (data_out),
    .busy       (busy),
    .RCO        (RCO),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Model: position in frame (-1 none, 0 start bit, 1..DL data, DL+1 stop)
  int            m_pos;
  bit            m_wait;
  bit            m_hold_full;
  logic [WS-1:0] m_hold;
  logic [WS-1:0] m_cur;
  bit            m_underrun;
  bit            m_done;
  bit            last_accept;

  bit            cap_on;
  int            cap_n;
  int            cap_lim;
  logic [31:0]   cap_v;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = -1; m_wait = 0; m_hold_full = 0; m_hold = '0;
    m_cur = '0; m_underrun = 0; m_done = 0; last_accept = 0;
  endtask

  function automatic logic exp_line();
    if (m_pos == 0) return 1'b0;
    if (m_pos >= 1 && m_pos <= DL) return m_cur[(m_pos - 1) % WS];
    return 1'b1;
  endfunction

  function automatic logic exp_rco();
    return (m_pos >= 1 && m_pos <= DL) && ((m_pos - 1) % WS == WS - 1);
  endfunction

  task automatic model_edge();
    bit acc;
    acc = word_valid && !m_hold_full;
    last_accept = acc && !reset;
    if (reset) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (m_pos < 0 && !m_wait) begin
      if (start) begin
        m_underrun = 0;
        if (m_hold_full) m_pos = 0;
        else m_wait = 1;
      end
    end else if (m_wait) begin
      if (m_hold_full) begin m_wait = 0; m_pos = 0; end
    end else if (m_pos == 0) begin
      m_cur = m_hold; m_hold_full = 0; m_pos = 1;
    end else if (m_pos <= DL) begin
      if (m_pos == DL) begin
        m_pos = STOP ? DL + 1 : -1;
        if (!STOP) m_done = 1;
      end else begin
        if ((m_pos - 1) % WS == WS - 1) begin
          if (m_hold_full) begin m_cur = m_hold; m_hold_full = 0; end
          else begin m_cur = '1; m_underrun = 1; end
        end
        m_pos++;
      end
    end else begin
      m_pos = -1; m_done = 1;
    end
    if (acc) begin m_hold = word_in; m_hold_full = 1; end
  endtask

  task automatic step();
    @(negedge clock);
    chk("data_out",   {31'd0, data_out},   {31'd0, exp_line()});
    chk("word_ready", {31'd0, word_ready}, {31'd0, !m_hold_full});
    chk("busy",       {31'd0, busy},
        {31'd0, (m_pos >= 0) || m_wait || start});
    chk("rco",        {31'd0, RCO},        {31'd0, exp_rco()});
    chk("done",       {31'd0, done},       {31'd0, m_done});
    chk("underrun",   {31'd0, underrun},   {31'd0, m_underrun});
    if (cap_on && cap_n < cap_lim) begin
      cap_v = {cap_v[30:0], data_out};
      cap_n++;
    end
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic feed(input logic [WS-1:0] w);
    int n = 0;
    word_valid = 1; word_in = w;
    do begin step(); n++; end while (!last_accept && n < 40);
    if (!last_accept) chk("feed_timeout", 32'd0, 32'd1);
    word_valid = 0;
  endtask

  task automatic cap_start(input int lim);
    cap_on = 1; cap_n = 0; cap_lim = lim; cap_v = '0;
  endtask

  initial begin
    int n;
    reset = 1; start = 0; word_in = '0; word_valid = 0;
    cap_on = 0; cap_n = 0; cap_lim = 0; cap_v = '0;
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    reset = 0;

    // Reset state
    step();
    chk("rst_line",  {31'd0, data_out},   32'd1);
    chk("rst_ready", {31'd0, word_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy},       32'd0);

    // Two-word frame A5, 3C
    feed(8'hA5);
    start = 1; step(); start = 0;
    word_valid = 1; word_in = 8'h3C;
    cap_start(17);
    for (int i = 0; i < 22; i++) begin
      step();
      if (last_accept) word_valid = 0;
    end
    chk("s2_line", cap_v, {15'd0, 17'b0_10100101_00111100});
    chk("s2_underrun", {31'd0, underrun}, 32'd0);
    cap_on = 0;

    // Start with empty hold, word 5 cycles later, no second word
    start = 1; step(); start = 0;
    for (int i = 0; i < 5; i++) step();
    chk("s3_wait_line", {31'd0, data_out}, 32'd1);
    feed(8'hFF);
    cap_start(18);
    for (int i = 0; i < 22; i++) step();
    chk("s3_line", cap_v, {14'd0, 18'b10_1111111111111111});
    chk("s4_underrun_set", {31'd0, underrun}, 32'd1);
    cap_on = 0;

    // New start clears underrun
    feed(8'h5A);
    start = 1; step(); start = 0;
    chk("s4_underrun_clr", {31'd0, underrun}, 32'd0);
    feed(8'h81);
    for (int i = 0; i < 22; i++) step();

    // Reset during the 5th data bit
    feed(8'h96);
    start = 1; step(); start = 0;
    n = 0;
    while (m_pos != 5 && n < 20) begin step(); n++; end
    reset = 1; step(); reset = 0;
    chk("s5_line",  {31'd0, data_out},   32'd1);
    chk("s5_busy",  {31'd0, busy},       32'd0);
    chk("s5_ready", {31'd0, word_ready}, 32'd1);
    for (int i = 0; i < 25; i++) begin
      step();
      chk("s5_no_done", {31'd0, done}, 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      word_valid = ($urandom_range(0, 2) != 0);
      word_in    = WS'($urandom);
      reset      = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 0; start = 0; word_valid = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
